// File: rtl/soc_system_pio_pkg.sv
// Shared register map, PWM width and status bit layout for the LED PWM PIO.
package soc_system_pio_pkg;

    typedef enum logic [2:0] {
        ADDR_DATA   = 3'd0,
        ADDR_MODE   = 3'd1,
        ADDR_PERIOD = 3'd2,
        ADDR_DUTY   = 3'd3,
        ADDR_OUTSET = 3'd4,
        ADDR_OUTCLR = 3'd5,
        ADDR_STATUS = 3'd6,
        ADDR_OUTPUT = 3'd7
    } reg_addr_e;

    localparam int PWM_W            = 8;
    localparam int STATUS_PHASE_BIT = 0;
    localparam int STATUS_PWM_BIT   = 1;

    // Full-scale duty must stay lit for all 256 counts, which cnt < duty alone cannot do.
    function automatic logic pwm_gate(input logic [PWM_W-1:0] cnt, input logic [PWM_W-1:0] duty);
        return (duty == {PWM_W{1'b1}}) || (cnt < duty);
    endfunction

endpackage

// File: rtl/soc_system_pio_tick_gen.sv
// Blink prescaler: counts 0..period and pulses tick for one cycle at the top of the count.
module soc_system_pio_tick_gen #(
    parameter int PRESCALE_W = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PRESCALE_W-1:0] period,
    input  logic                  clear,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == period);

    // A clear arrives with every period write, so the count can never sit above period.
    always_comb begin
        cnt_d = cnt_q + PRESCALE_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/soc_system_led_pwm_pio.sv
// Avalon-MM output PIO with atomic set/clear, per-bit blink and a global PWM brightness gate.
module soc_system_led_pwm_pio
    import soc_system_pio_pkg::*;
#(
    parameter int          WIDTH          = 10,
    parameter logic [31:0] RESET_VALUE    = 32'd0,
    parameter int          PRESCALE_W     = 26,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd24_999_999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]      data_q, data_d;
    logic [WIDTH-1:0]      mode_q, mode_d;
    logic [PRESCALE_W-1:0] period_q, period_d;
    logic [PWM_W-1:0]      duty_q, duty_d;
    logic                  phase_q, phase_d;
    logic [PWM_W-1:0]      pwm_cnt_q;
    logic [WIDTH-1:0]      out_q, out_d;
    logic                  wr_en;
    logic                  period_wr;
    logic                  tick;
    logic                  pwm_on;
    logic                  unusedWritedata;

    assign wr_en           = chipselect & ~write_n;
    assign period_wr       = wr_en && (address == ADDR_PERIOD);
    assign pwm_on          = pwm_gate(pwm_cnt_q, duty_q);
    assign unusedWritedata = ^writedata;
    assign out_port        = out_q;

    soc_system_pio_tick_gen #(
        .PRESCALE_W(PRESCALE_W)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .period(period_q),
        .clear (period_wr),
        .tick  (tick)
    );

    always_comb begin
        data_d   = data_q;
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:   data_d   = writedata[WIDTH-1:0];
                ADDR_MODE:   mode_d   = writedata[WIDTH-1:0];
                ADDR_PERIOD: period_d = writedata[PRESCALE_W-1:0];
                ADDR_DUTY:   duty_d   = writedata[PWM_W-1:0];
                ADDR_OUTSET: data_d   = data_q | writedata[WIDTH-1:0];
                ADDR_OUTCLR: data_d   = data_q & ~writedata[WIDTH-1:0];
                default:     ;
            endcase
        end

        // A period write restarts the blink cycle and takes priority over a coincident tick.
        phase_d = phase_q;
        if (period_wr) begin
            phase_d = 1'b1;
        end else if (tick) begin
            phase_d = ~phase_q;
        end

        out_d = data_q & (~mode_q | {WIDTH{phase_q}}) & {WIDTH{pwm_on}};
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_q);
            ADDR_MODE:   readdata = 32'(mode_q);
            ADDR_PERIOD: readdata = 32'(period_q);
            ADDR_DUTY:   readdata = 32'(duty_q);
            ADDR_STATUS: begin
                readdata[STATUS_PHASE_BIT] = phase_q;
                readdata[STATUS_PWM_BIT]   = pwm_on;
            end
            ADDR_OUTPUT: readdata = 32'(out_q);
            default:     readdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= WIDTH'(RESET_VALUE);
            mode_q    <= '0;
            period_q  <= PRESCALE_W'(DEFAULT_PERIOD);
            duty_q    <= {PWM_W{1'b1}};
            phase_q   <= 1'b1;
            pwm_cnt_q <= '0;
            out_q     <= '0;
        end else begin
            data_q    <= data_d;
            mode_q    <= mode_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            phase_q   <= phase_d;
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
            out_q     <= out_d;
        end
    end

endmodule

// File: tb/tb_soc_system_led_pwm_pio.sv
// Scoreboard bench for soc_system_led_pwm_pio: expectations are queued as stimulus is applied.
module tb_soc_system_led_pwm_pio;
    import soc_system_pio_pkg::*;

    localparam int WIDTH = 10;

    logic             clk;
    logic             reset;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } expEntry_t;

    expEntry_t expQ[$];
    int checks = 0;
    int errors = 0;

    soc_system_led_pwm_pio #(
        .WIDTH         (WIDTH),
        .RESET_VALUE   (32'h155),
        .PRESCALE_W    (26),
        .DEFAULT_PERIOD(32'd24_999_999)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic pushExp(input string tag, input logic [31:0] e);
        expEntry_t ent;
        ent.tag = tag;
        ent.exp = e;
        expQ.push_back(ent);
    endtask

    task automatic popCompare(input logic [31:0] actual);
        expEntry_t ent;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd1);
            return;
        end
        ent = expQ.pop_front();
        checkOutput(ent.tag, actual, ent.exp);
    endtask

    // Write is presented at a falling edge and sampled at the following rising edge.
    task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        write_n    = 1'b1;
        chipselect = 1'b0;
    endtask

    task automatic readReg(input logic [2:0] a, input string tag, input logic [31:0] e);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        pushExp(tag, e);
        #1;
        popCompare(readdata);
    endtask

    task automatic expectOut(input string tag, input logic [31:0] e);
        pushExp(tag, e);
        popCompare(32'(out_port));
    endtask

    // Entered just after a period-3 write; phase holds 4 cycles, out lags phase by one edge.
    task automatic blinkCheck(input int n);
        logic ph;
        for (int j = 0; j < n; j++) begin
            ph = (((j / 4) % 2) == 0);
            readReg(ADDR_STATUS, "blink_status", {30'd0, 1'b1, ph});
            pushExp("blink_out", 32'h002 | 32'(ph));
            @(negedge clk);
            popCompare(32'(out_port));
        end
    endtask

    task automatic pwmCheck(input logic [7:0] duty, input int expHigh, input string tag);
        int high;
        int bad;
        high = 0;
        bad  = 0;
        applyStimulus(ADDR_DUTY, 32'(duty));
        readReg(ADDR_DUTY, "pwm_duty_read", 32'(duty));
        @(negedge clk);
        pushExp(tag, 32'(expHigh));
        pushExp("pwm_levels", 32'd0);
        for (int k = 0; k < 256; k++) begin
            if (out_port == 10'h3FF) high++;
            else if (out_port != 10'h000) bad++;
            @(negedge clk);
        end
        popCompare(32'(high));
        popCompare(32'(bad));
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        repeat (2) @(negedge clk);
        expectOut("reset_out", 32'h0);
        reset = 1'b0;

        readReg(ADDR_DATA,   "reset_data",   32'h155);
        readReg(ADDR_MODE,   "reset_mode",   32'h0);
        readReg(ADDR_PERIOD, "reset_period", 32'd24_999_999);
        readReg(ADDR_DUTY,   "reset_duty",   32'hFF);
        readReg(ADDR_STATUS, "reset_status", 32'h3);
        @(negedge clk);
        expectOut("first_edge_out", 32'h155);

        applyStimulus(ADDR_DATA, 32'h3A5);
        expectOut("data_latency_old", 32'h155);
        readReg(ADDR_DATA, "data_read", 32'h3A5);
        @(negedge clk);
        expectOut("data_latency_new", 32'h3A5);

        applyStimulus(ADDR_DATA, 32'h0F0);
        applyStimulus(ADDR_OUTSET, 32'h00F);
        readReg(ADDR_DATA, "outset_data", 32'h0FF);
        applyStimulus(ADDR_OUTCLR, 32'h0C0);
        readReg(ADDR_DATA, "outclr_data", 32'h03F);
        readReg(ADDR_OUTSET, "outset_read", 32'h0);
        readReg(ADDR_OUTCLR, "outclr_read", 32'h0);
        applyStimulus(ADDR_OUTSET, 32'hFFFF_FC00);
        readReg(ADDR_DATA, "outset_high_bits", 32'h03F);
        applyStimulus(ADDR_OUTCLR, 32'hFFFF_FC00);
        readReg(ADDR_DATA, "outclr_high_bits", 32'h03F);
        readReg(ADDR_OUTPUT, "output_read", 32'h03F);

        applyStimulus(ADDR_MODE, 32'h001);
        applyStimulus(ADDR_DATA, 32'h003);
        applyStimulus(ADDR_PERIOD, 32'd3);
        readReg(ADDR_PERIOD, "period_read", 32'd3);
        blinkCheck(27);
        // Prescaler count is now 3, so this write lands on a tick while phase is 1.
        applyStimulus(ADDR_PERIOD, 32'd3);
        blinkCheck(12);

        applyStimulus(ADDR_MODE, 32'h000);
        applyStimulus(ADDR_DATA, 32'h3FF);
        pwmCheck(8'd64,  64,  "pwm_duty64_high");
        pwmCheck(8'd0,   0,   "pwm_duty0_high");
        pwmCheck(8'hFF,  256, "pwm_duty255_high");

        applyStimulus(ADDR_MODE, 32'h001);
        applyStimulus(ADDR_PERIOD, 32'd3);
        repeat (5) @(negedge clk);
        expectOut("pre_reset_out_hi", 32'(out_port[9:1]) << 1 | 32'(out_port[0]) | 32'h3FE);
        #1 reset = 1'b1;
        #1;
        expectOut("async_reset_out", 32'h0);
        readReg(ADDR_DATA,   "async_reset_data",   32'h155);
        readReg(ADDR_MODE,   "async_reset_mode",   32'h0);
        readReg(ADDR_PERIOD, "async_reset_period", 32'd24_999_999);
        readReg(ADDR_DUTY,   "async_reset_duty",   32'hFF);
        readReg(ADDR_STATUS, "async_reset_status", 32'h3);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expectOut("post_reset_out", 32'h155);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
